// File: rtl/filt_boxcar_var_pkg.sv
// Width helpers shared by the variable-length boxcar filter, its interface and delay line.
package filt_boxcar_var_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Accumulator holds up to 2^LOG2_MAX_LENGTH samples without overflow.
  function automatic int acc_w(input int data_w, input int log2_max);
    return data_w + log2_max;
  endfunction

  function automatic int ptr_w(input int chans, input int log2_max);
    return max1(clog2(chans << log2_max));
  endfunction

endpackage

// File: rtl/filt_boxcar_var_if.sv
// Sample/config/result bundle between the capture front end and the boxcar filter.
interface filt_boxcar_var_if
  import filt_boxcar_var_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_CHANNELS    = 4,
  parameter int LOG2_MAX_LENGTH = 5
);
  localparam int CH_W  = max1(clog2(NUM_CHANNELS));
  localparam int CFG_W = max1(clog2(LOG2_MAX_LENGTH + 1));

  logic                  clr;
  logic [CFG_W-1:0]      cfg_log2_len;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  out_valid;
  logic [CH_W-1:0]       out_chan;
  logic                  out_full;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output clr, cfg_log2_len, in_valid, din,
    input  out_valid, out_chan, out_full, dout
  );

  modport slave (
    input  clr, cfg_log2_len, in_valid, din,
    output out_valid, out_chan, out_full, dout
  );

endinterface

// File: rtl/filt_boxcar_var_dly.sv
// Simple dual-port delay memory with registered, read-before-write output.
module filt_boxcar_var_dly #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int PTR_W      = 7,
  parameter int USE_RAM    = 0
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_rdata;

  // At maximum window the read and write addresses coincide; the old word must be returned.
  generate
    if (USE_RAM != 0) begin : g_ram
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
      end
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i_we && (i_waddr == PTR_W'(i))) r_mem[i] <= i_wdata;
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
      end
    end
  endgenerate

  assign o_rdata = r_rdata;

endmodule

// File: rtl/filt_boxcar_var.sv
// Time-interleaved moving-average filter; window 2^L per channel, L latched at rst/clr.
// Sample accepted at edge t appears on the output at edge t+3.
module filt_boxcar_var
  import filt_boxcar_var_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_CHANNELS    = 4,
  parameter int LOG2_MAX_LENGTH = 5,
  parameter int SIGNED          = 1,
  parameter int DLY_USE_RAM     = 0
) (
  input logic              clk,
  input logic              rst,
  filt_boxcar_var_if.slave bus
);
  localparam int ACC_W  = acc_w(DATA_WIDTH, LOG2_MAX_LENGTH);
  localparam int DEPTH  = NUM_CHANNELS << LOG2_MAX_LENGTH;
  localparam int PTR_W  = ptr_w(NUM_CHANNELS, LOG2_MAX_LENGTH);
  localparam int FILL_W = clog2(DEPTH + 1);
  localparam int CH_W   = max1(clog2(NUM_CHANNELS));
  localparam int CFG_W  = max1(clog2(LOG2_MAX_LENGTH + 1));

  function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_WIDTH-1:0] d);
    if (SIGNED != 0) return {{LOG2_MAX_LENGTH{d[DATA_WIDTH-1]}}, d};
    return {{LOG2_MAX_LENGTH{1'b0}}, d};
  endfunction

  // Divide by 2^L rounding toward -inf, then truncate to the sample width.
  function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [ACC_W-1:0] a,
                                                  input logic [CFG_W-1:0] l);
    if (SIGNED != 0) return DATA_WIDTH'(a >>> l);
    return DATA_WIDTH'($unsigned(a) >> l);
  endfunction

  logic [CFG_W-1:0]        r_log2_len, w_cfg_len;
  logic [PTR_W-1:0]        r_wr_ptr, w_rd_addr;
  logic [PTR_W:0]          w_rd_sum;
  logic [FILL_W-1:0]       r_fill, w_span;
  logic [CH_W-1:0]         r_chan;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    r_vld_p0, r_vld_p1, r_vld_p2;
  logic signed [ACC_W-1:0] r_din_p0, r_delta_p1, r_sum_p2, w_old, w_acc_new;
  logic [CH_W-1:0]         r_chan_p0, r_chan_p1, r_chan_p2;
  logic                    r_zero_p0, r_full_p0, r_full_p1, r_full_p2;
  logic signed [ACC_W-1:0] r_acc [NUM_CHANNELS];
  logic                    r_out_valid, r_out_full;
  logic [CH_W-1:0]         r_out_chan;
  logic [DATA_WIDTH-1:0]   r_out_dout;

  assign w_accept  = bus.in_valid & ~bus.clr;
  assign w_cfg_len = (bus.cfg_log2_len > CFG_W'(LOG2_MAX_LENGTH)) ? CFG_W'(LOG2_MAX_LENGTH)
                                                                  : bus.cfg_log2_len;
  assign w_span    = FILL_W'(NUM_CHANNELS) << r_log2_len;
  assign w_rd_sum  = {1'b0, r_wr_ptr} + (PTR_W+1)'(DEPTH) - (PTR_W+1)'(w_span);
  assign w_rd_addr = (w_rd_sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(w_rd_sum - (PTR_W+1)'(DEPTH))
                                                     : PTR_W'(w_rd_sum);

  filt_boxcar_var_dly #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W),
    .USE_RAM    (DLY_USE_RAM)
  ) u_dly (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.din),
    .i_re    (w_accept),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_log2_len <= w_cfg_len;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_chan     <= '0;
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
    end else begin
      r_vld_p0 <= bus.in_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      if (bus.in_valid) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        r_chan   <= (r_chan == CH_W'(NUM_CHANNELS - 1)) ? '0 : r_chan + 1'b1;
        if (r_fill < w_span) r_fill <= r_fill + 1'b1;
      end
    end
  end

  // p0: capture sample; until the window has filled, the departing sample counts as zero
  always_ff @(posedge clk) begin
    r_din_p0  <= ext(bus.din);
    r_chan_p0 <= r_chan;
    r_zero_p0 <= (r_fill < w_span);
    r_full_p0 <= (({1'b0, r_fill} + 1'b1) >= {1'b0, w_span});
  end

  // p1: new sample minus departing sample
  assign w_old = r_zero_p0 ? '0 : ext(w_rdata);

  always_ff @(posedge clk) begin
    r_delta_p1 <= r_din_p0 - w_old;
    r_chan_p1  <= r_chan_p0;
    r_full_p1  <= r_full_p0;
  end

  // p2: single-cycle read-modify-write so consecutive hits on one channel chain correctly
  assign w_acc_new = r_acc[r_chan_p1] + r_delta_p1;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_acc[i] <= '0;
    end else if (r_vld_p1) begin
      r_acc[r_chan_p1] <= w_acc_new;
    end
  end

  always_ff @(posedge clk) begin
    r_sum_p2  <= w_acc_new;
    r_chan_p2 <= r_chan_p1;
    r_full_p2 <= r_full_p1;
  end

  // p3: output register
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      r_out_valid <= 1'b0;
      r_out_dout  <= '0;
      r_out_chan  <= '0;
      r_out_full  <= 1'b0;
    end else begin
      r_out_valid <= r_vld_p2;
      if (r_vld_p2) begin
        r_out_dout <= scale(r_sum_p2, r_log2_len);
        r_out_chan <= r_chan_p2;
        r_out_full <= r_full_p2;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_out_dout;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_full  = r_out_full;

endmodule

// File: tb/tb_filt_boxcar_var.sv
// Scoreboard bench: a 4-channel signed register-delay instance and a 1-channel unsigned RAM instance.
module tb_filt_boxcar_var;
  import filt_boxcar_var_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  ch;
    logic        full;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filt_boxcar_var_if #(.DATA_WIDTH(16), .NUM_CHANNELS(4), .LOG2_MAX_LENGTH(5)) bus4 ();
  filt_boxcar_var_if #(.DATA_WIDTH(16), .NUM_CHANNELS(1), .LOG2_MAX_LENGTH(5)) bus1 ();

  filt_boxcar_var #(
    .DATA_WIDTH(16), .NUM_CHANNELS(4), .LOG2_MAX_LENGTH(5), .SIGNED(1), .DLY_USE_RAM(0)
  ) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  filt_boxcar_var #(
    .DATA_WIDTH(16), .NUM_CHANNELS(1), .LOG2_MAX_LENGTH(5), .SIGNED(0), .DLY_USE_RAM(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q4[$];
  exp_t q1[$];
  int   samp[$];
  int   L4 = 3;
  int   n_acc4 = 0;
  int   n_out4 = 0;
  exp_t m4, m1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor(sum of the last 2^L samples of this channel / 2^L), missing samples = 0.
  task automatic model4(input int d);
    exp_t e;
    int n, s, idx, r, c;
    samp.push_back(d);
    n = samp.size();
    s = 0;
    for (int j = 0; j < (1 << L4); j++) begin
      idx = n - 1 - 4 * j;
      if (idx >= 0) s += samp[idx];
    end
    r = s >>> L4;
    c = (n - 1) % 4;
    e.d    = r[15:0];
    e.ch   = c[1:0];
    e.full = (n >= (4 << L4));
    q4.push_back(e);
  endtask

  task automatic step4(input logic v, input int d);
    @(posedge clk); #1;
    bus4.in_valid = v;
    bus4.din      = d[15:0];
    if (v) begin
      model4(d);
      n_acc4++;
    end
  endtask

  task automatic step1(input logic v, input int d, input int ed, input logic ef);
    exp_t e;
    @(posedge clk); #1;
    bus1.in_valid = v;
    bus1.din      = d[15:0];
    if (v) begin
      e.d    = ed[15:0];
      e.ch   = 2'd0;
      e.full = ef;
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
    end
  endtask

  task automatic clr4(input int cfg, input logic with_v, input int d);
    @(posedge clk); #1;
    bus4.clr          = 1'b1;
    bus4.cfg_log2_len = cfg[2:0];
    bus4.in_valid     = with_v;
    bus4.din          = d[15:0];
    @(posedge clk); #1;
    q4.delete();
    samp.delete();
    L4 = (cfg > 5) ? 5 : cfg;
    bus4.clr      = 1'b0;
    bus4.in_valid = 1'b0;
  endtask

  task automatic clr1(input int cfg);
    @(posedge clk); #1;
    bus1.clr          = 1'b1;
    bus1.cfg_log2_len = cfg[2:0];
    bus1.in_valid     = 1'b0;
    @(posedge clk); #1;
    q1.delete();
    bus1.clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus4.out_valid) begin
      if (q4.size() == 0) begin
        chk("extra_valid4", {31'b0, bus4.out_valid}, 32'd0);
      end else begin
        m4 = q4.pop_front();
        n_out4++;
        chk("dout4", {16'b0, bus4.dout}, {16'b0, m4.d});
        chk("chan4", {30'b0, bus4.out_chan}, {30'b0, m4.ch});
        chk("full4", {31'b0, bus4.out_full}, {31'b0, m4.full});
      end
    end
    if (bus1.out_valid) begin
      if (q1.size() == 0) begin
        chk("extra_valid1", {31'b0, bus1.out_valid}, 32'd0);
      end else begin
        m1 = q1.pop_front();
        chk("dout1", {16'b0, bus1.dout}, {16'b0, m1.d});
        chk("chan1", {31'b0, bus1.out_chan}, 32'd0);
        chk("full1", {31'b0, bus1.out_full}, {31'b0, m1.full});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t1[8];
    int pt[5];
    int uf[6];
    int sg[12];
    int tl[8];
    int out0, acc0;
    t1 = '{25, 50, 75, 100, 100, 100, 100, 100};
    pt = '{65535, 0, 32768, 1, 4660};
    uf = '{16383, 32767, 49151, 65535, 65535, 65535};
    sg = '{-3, 5, -1, 7, -4, 6, -2, 8, -32768, 32767, 0, -1};
    tl = '{7, -7, 100, 3, 9, -9, 50, 1};

    rst = 1'b1;
    bus4.clr = 1'b0; bus4.cfg_log2_len = 3'd3; bus4.in_valid = 1'b0; bus4.din = '0;
    bus1.clr = 1'b0; bus1.cfg_log2_len = 3'd2; bus1.in_valid = 1'b0; bus1.din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid4", {31'b0, bus4.out_valid}, 32'd0);
    chk("rst_dout4",  {16'b0, bus4.dout}, 32'd0);
    chk("rst_chan4",  {30'b0, bus4.out_chan}, 32'd0);
    chk("rst_full4",  {31'b0, bus4.out_full}, 32'd0);
    chk("rst_valid1", {31'b0, bus1.out_valid}, 32'd0);
    rst = 1'b0;

    // single channel, L=2, constant input, back-to-back on one accumulator
    for (int i = 0; i < 8; i++) step1(1'b1, 100, t1[i], i >= 3);
    idle(1);
    // L=0 passthrough
    clr1(0);
    for (int i = 0; i < 5; i++) step1(1'b1, pt[i], pt[i], 1'b1);
    idle(1);
    // unsigned full-scale at L=2
    clr1(2);
    for (int i = 0; i < 6; i++) step1(1'b1, 65535, uf[i], i >= 3);
    idle(5);

    // four channels, L=3, channel c fed 10*(c+1)
    for (int i = 0; i < 40; i++) step4(1'b1, 10 * (i % 4 + 1));
    idle(5);

    // signed floor rounding at L=1
    clr4(1, 1'b0, 0);
    for (int i = 0; i < 12; i++) step4(1'b1, sg[i]);
    // out-of-range exponent clamps to 5; full-scale window then departing samples
    clr4(7, 1'b0, 0);
    for (int i = 0; i < 128; i++) step4(1'b1, 32767);
    for (int i = 0; i < 8; i++) step4(1'b1, 0);
    // clr mid-stream with a colliding sample; new L=1 must see no stale history
    clr4(1, 1'b1, 12345);
    for (int i = 0; i < 8; i++) step4(1'b1, tl[i]);
    idle(5);

    // random gaps at L=2
    clr4(2, 1'b0, 0);
    out0 = n_out4;
    acc0 = n_acc4;
    for (int i = 0; i < 200; i++)
      step4(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768);
    idle(6);
    chk("outcnt4", n_out4 - out0, n_acc4 - acc0);

    // reset with two samples in flight
    step4(1'b1, 1000);
    step4(1'b1, -1000);
    @(posedge clk); #1;
    rst = 1'b1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q4.delete();
    q1.delete();
    samp.delete();
    L4 = int'(bus4.cfg_log2_len);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_valid", {31'b0, bus4.out_valid}, 32'd0);
    end
    chk("rst2_dout4", {16'b0, bus4.dout}, 32'd0);
    chk("rst2_chan4", {30'b0, bus4.out_chan}, 32'd0);
    chk("rst2_full4", {31'b0, bus4.out_full}, 32'd0);
    for (int i = 0; i < 6; i++) step4(1'b1, 40 * (i + 1));
    idle(8);

    chk("q4_left", q4.size(), 32'd0);
    chk("q1_left", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
